pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the IF/ID and ID/EX pipeline registers.
//  - Detects load-use hazards and inserts one bubble into ID/EX.
//  - Freezes the front end while a multi-cycle EX op (mul/div) occupies EX.
//  - Flushes the wrong-path instructions on a taken branch resolved in EX.
//  - Sits beside the decoder and drives the stall/flush controls of the PC, if_id and id_exe.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  // Register-file address width; x0 is hard-wired zero and never hazards.
  localparam int DEF_RADDR_WIDTH  = 5;
  // Multi-cycle counter width; longest EX op holds for 2^W-1 extra cycles.
  localparam int DEF_MC_CNT_WIDTH = 4;

  localparam logic [DEF_RADDR_WIDTH-1:0] ZERO_REG      = '0;
  localparam logic                       WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,  // normal issue, hazards evaluated every cycle
    ST_MC  = 2'b01   // multi-cycle op holding EX, front end frozen
  } phc_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: EX-stage load whose destination feeds an ID source.
// Latency: purely combinational.
// Backpressure: none; result is consumed by the sequencer in the same cycle.
//
// Ports:
//   id_rs1_addr/id_rs1_re, id_rs2_addr/id_rs2_re : ID-stage source operands
//   ex_reg_we, ex_reg_waddr, ex_is_load          : EX-stage destination info
//   load_use                                      : hazard present this cycle
module pipe_hazard_ctrl_load_use_detect #(
  parameter int RADDR_WIDTH = 5
) (
  input  logic [RADDR_WIDTH-1:0] id_rs1_addr,
  input  logic                   id_rs1_re,
  input  logic [RADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                   id_rs2_re,
  input  logic                   ex_reg_we,
  input  logic [RADDR_WIDTH-1:0] ex_reg_waddr,
  input  logic                   ex_is_load,
  output logic                   load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic ex_dst_live;

  // Writes to x0 are discarded by the register file, so they can never hazard.
  assign ex_dst_live = ex_is_load & ex_reg_we & (ex_reg_waddr != '0);
  assign rs1_hit     = id_rs1_re & (id_rs1_addr == ex_reg_waddr);
  assign rs2_hit     = id_rs2_re & (id_rs2_addr == ex_reg_waddr);
  assign load_use    = ex_dst_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer driving PC / if_id / id_exe stall and flush controls.
// Latency: outputs combinational from state, counter and current inputs.
// Backpressure: multi-cycle EX ops freeze the front end; load-use inserts one bubble.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   id_rs1_*/id_rs2_*        : ID-stage source operands
//   ex_reg_we_i/ex_reg_waddr_i/ex_is_load_i : EX-stage destination info
//   ex_mc_start_i/ex_mc_cycles_i : multi-cycle op in EX and its extra cycles
//   ex_branch_taken_i        : taken branch/jump resolved in EX
//   stall_pc_o, stall_if_id_o, stall_id_exe_o, flush_if_id_o, flush_id_exe_o, busy_o
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RADDR_WIDTH  = DEF_RADDR_WIDTH,
  parameter int MC_CNT_WIDTH = DEF_MC_CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [RADDR_WIDTH-1:0]  id_rs1_addr_i,
  input  logic                    id_rs1_re_i,
  input  logic [RADDR_WIDTH-1:0]  id_rs2_addr_i,
  input  logic                    id_rs2_re_i,
  input  logic                    ex_reg_we_i,
  input  logic [RADDR_WIDTH-1:0]  ex_reg_waddr_i,
  input  logic                    ex_is_load_i,
  input  logic                    ex_mc_start_i,
  input  logic [MC_CNT_WIDTH-1:0] ex_mc_cycles_i,
  input  logic                    ex_branch_taken_i,
  output logic                    stall_pc_o,
  output logic                    stall_if_id_o,
  output logic                    stall_id_exe_o,
  output logic                    flush_if_id_o,
  output logic                    flush_id_exe_o,
  output logic                    busy_o
);

  localparam logic [MC_CNT_WIDTH-1:0] CNT_ONE = MC_CNT_WIDTH'(1);

  phc_state_t              state;
  phc_state_t              state_nxt;
  logic [MC_CNT_WIDTH-1:0] cnt;
  logic [MC_CNT_WIDTH-1:0] cnt_nxt;

  logic load_use;
  logic mc_go;

  logic stall_pc;
  logic stall_if_id;
  logic stall_id_exe;
  logic flush_if_id;
  logic flush_id_exe;
  logic busy;

  pipe_hazard_ctrl_load_use_detect #(
    .RADDR_WIDTH (RADDR_WIDTH)
  ) u_load_use_detect (
    .id_rs1_addr  (id_rs1_addr_i),
    .id_rs1_re    (id_rs1_re_i),
    .id_rs2_addr  (id_rs2_addr_i),
    .id_rs2_re    (id_rs2_re_i),
    .ex_reg_we    (ex_reg_we_i),
    .ex_reg_waddr (ex_reg_waddr_i),
    .ex_is_load   (ex_is_load_i),
    .load_use     (load_use)
  );

  // A zero-cycle "multi-cycle" op behaves exactly like a single-cycle one.
  assign mc_go = ex_mc_start_i & (ex_mc_cycles_i != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_exe = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    busy         = 1'b0;

    case (state)
      ST_RUN: begin
        if (ex_branch_taken_i) begin
          // Wrong-path instructions are squashed; anything they would have
          // stalled on is irrelevant.
          flush_if_id  = 1'b1;
          flush_id_exe = 1'b1;
        end else if (mc_go) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_exe = 1'b1;
          cnt_nxt      = ex_mc_cycles_i;
          state_nxt    = ST_MC;
        end else if (load_use) begin
          // Hold the consumer in ID and push a bubble into EX.
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          flush_id_exe = 1'b1;
        end
      end

      ST_MC: begin
        // ex_mc_start_i is deliberately not looked at here: the held op
        // still presents it and must not re-arm the counter.
        busy = 1'b1;
        if (cnt > CNT_ONE) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_exe = 1'b1;
          cnt_nxt      = cnt - CNT_ONE;
        end else begin
          // Final cycle (cnt==0 is unreachable but handled the same way,
          // and the counter is clamped so it can never wrap).
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
          if (ex_branch_taken_i) begin
            flush_if_id  = 1'b1;
            flush_id_exe = 1'b1;
          end else if (load_use) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            flush_id_exe = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are forced low for the whole time reset is asserted, not just
  // after the registers have cleared.
  assign stall_pc_o     = rst_i & stall_pc;
  assign stall_if_id_o  = rst_i & stall_if_id;
  assign stall_id_exe_o = rst_i & stall_id_exe;
  assign flush_if_id_o  = rst_i & flush_if_id;
  assign flush_id_exe_o = rst_i & flush_id_exe;
  assign busy_o         = rst_i & busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares.
// Expected vector bit order: {stall_pc, stall_if_id, stall_id_exe, flush_if_id, flush_id_exe, busy}.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_addr;
  logic       rs1_re;
  logic [4:0] rs2_addr;
  logic       rs2_re;
  logic       reg_we;
  logic [4:0] reg_waddr;
  logic       is_load;
  logic       mc_start;
  logic [3:0] mc_cycles;
  logic       br_taken;
  logic       stall_pc;
  logic       stall_if_id;
  logic       stall_id_exe;
  logic       flush_if_id;
  logic       flush_id_exe;
  logic       busy;

  pipe_hazard_ctrl #(
    .RADDR_WIDTH  (5),
    .MC_CNT_WIDTH (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .id_rs1_addr_i     (rs1_addr),
    .id_rs1_re_i       (rs1_re),
    .id_rs2_addr_i     (rs2_addr),
    .id_rs2_re_i       (rs2_re),
    .ex_reg_we_i       (reg_we),
    .ex_reg_waddr_i    (reg_waddr),
    .ex_is_load_i      (is_load),
    .ex_mc_start_i     (mc_start),
    .ex_mc_cycles_i    (mc_cycles),
    .ex_branch_taken_i (br_taken),
    .stall_pc_o        (stall_pc),
    .stall_if_id_o     (stall_if_id),
    .stall_id_exe_o    (stall_id_exe),
    .flush_if_id_o     (flush_if_id),
    .flush_id_exe_o    (flush_id_exe),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed output patterns.
  localparam logic [5:0] E_ZERO   = 6'b000000; // nothing asserted
  localparam logic [5:0] E_LU     = 6'b110010; // load-use bubble in ST_RUN
  localparam logic [5:0] E_MC_GO  = 6'b111000; // ST_RUN cycle that launches a mc op
  localparam logic [5:0] E_MC     = 6'b111001; // ST_MC, cnt>1
  localparam logic [5:0] E_FIN    = 6'b000001; // ST_MC final cycle, no hazard
  localparam logic [5:0] E_BR     = 6'b000110; // branch flush in ST_RUN
  localparam logic [5:0] E_FIN_BR = 6'b000111; // branch flush on final mc cycle
  localparam logic [5:0] E_FIN_LU = 6'b110011; // load-use on final mc cycle

  typedef struct {
    string      name;
    logic [5:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_entry_t e;
      logic [5:0] act;
      e   = sb_q.pop_front();
      act = {stall_pc, stall_if_id, stall_id_exe, flush_if_id, flush_id_exe, busy};
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_addr  = '0; rs1_re = 1'b0;
    rs2_addr  = '0; rs2_re = 1'b0;
    reg_we    = 1'b0; reg_waddr = '0; is_load = 1'b0;
    mc_start  = 1'b0; mc_cycles = '0; br_taken = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [5:0] exp);
    sb_entry_t e;
    e.name = nm;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic set_load(input logic [4:0] wa);
    is_load = 1'b1; reg_we = 1'b1; reg_waddr = wa;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;

    // Reset: outputs forced low even with aggressive inputs present.
    mc_start = 1'b1; mc_cycles = 4'd3; br_taken = 1'b1;
    set_load(5'd5); rs1_addr = 5'd5; rs1_re = 1'b1;
    tick(); expect_out("reset_hold0", E_ZERO);
    tick(); expect_out("reset_hold1", E_ZERO);
    tick(); clr(); rst_n = 1'b1; expect_out("reset_release", E_ZERO);

    // 1. Load-use hazards.
    tick(); set_load(5'd5); rs1_addr = 5'd5; rs1_re = 1'b1;
    expect_out("lu_rs1", E_LU);
    tick(); clr(); expect_out("lu_rs1_after", E_ZERO);
    tick(); set_load(5'd0); rs1_addr = 5'd0; rs1_re = 1'b1;
    expect_out("lu_x0", E_ZERO);
    tick(); clr(); set_load(5'd7); rs2_addr = 5'd7; rs2_re = 1'b1; rs1_addr = 5'd3; rs1_re = 1'b1;
    expect_out("lu_rs2", E_LU);
    tick(); rs2_re = 1'b0; expect_out("lu_rs2_no_re", E_ZERO);
    tick(); rs2_re = 1'b1; is_load = 1'b0; expect_out("lu_not_load", E_ZERO);
    tick(); is_load = 1'b1; reg_we = 1'b0; expect_out("lu_no_we", E_ZERO);

    // 2. Multi-cycle, cycles=3 then cycles=1 then cycles=0.
    tick(); clr(); mc_start = 1'b1; mc_cycles = 4'd3; expect_out("mc3_go", E_MC_GO);
    tick(); expect_out("mc3_cnt3", E_MC);
    tick(); expect_out("mc3_cnt2", E_MC);
    tick(); expect_out("mc3_final", E_FIN);
    tick(); clr(); expect_out("mc3_after", E_ZERO);
    tick(); mc_start = 1'b1; mc_cycles = 4'd1; expect_out("mc1_go", E_MC_GO);
    tick(); expect_out("mc1_final", E_FIN);
    tick(); clr(); expect_out("mc1_after", E_ZERO);
    tick(); mc_start = 1'b1; mc_cycles = 4'd0; expect_out("mc0_noop", E_ZERO);

    // 3. Branch overrides both mc_go and load_use in ST_RUN.
    tick(); clr(); br_taken = 1'b1; mc_start = 1'b1; mc_cycles = 4'd3;
    set_load(5'd9); rs1_addr = 5'd9; rs1_re = 1'b1;
    expect_out("br_prio", E_BR);
    tick(); clr(); expect_out("br_prio_stay_run", E_ZERO);

    // 4. Branch ignored mid-op, honoured on the final cycle.
    tick(); mc_start = 1'b1; mc_cycles = 4'd3; expect_out("mcbr_go", E_MC_GO);
    tick(); br_taken = 1'b1; expect_out("mcbr_cnt3_ignored", E_MC);
    tick(); br_taken = 1'b0; expect_out("mcbr_cnt2", E_MC);
    tick(); br_taken = 1'b1; expect_out("mcbr_final_flush", E_FIN_BR);
    tick(); clr(); expect_out("mcbr_after", E_ZERO);
    // Load-use seen on the final cycle.
    tick(); mc_start = 1'b1; mc_cycles = 4'd2; expect_out("mclu_go", E_MC_GO);
    tick(); set_load(5'd4); rs1_addr = 5'd4; rs1_re = 1'b1; expect_out("mclu_cnt2_ignored", E_MC);
    tick(); expect_out("mclu_final", E_FIN_LU);
    tick(); clr(); expect_out("mclu_after", E_ZERO);

    // 5. Async reset in the middle of an op, then a clean restart.
    tick(); mc_start = 1'b1; mc_cycles = 4'd3; expect_out("rst_mid_go", E_MC_GO);
    tick(); expect_out("rst_mid_cnt3", E_MC);
    tick(); #1 rst_n = 1'b0; expect_out("rst_mid_async", E_ZERO);
    tick(); expect_out("rst_mid_held", E_ZERO);
    tick(); rst_n = 1'b1; mc_cycles = 4'd2; expect_out("rst_restart_go", E_MC_GO);
    tick(); expect_out("rst_restart_cnt2", E_MC);
    tick(); expect_out("rst_restart_final", E_FIN);
    tick(); clr(); expect_out("rst_restart_after", E_ZERO);

    // 6. Maximum count with mc_start held throughout: 15 stall cycles.
    tick(); mc_start = 1'b1; mc_cycles = 4'd15; expect_out("mc15_go", E_MC_GO);
    for (int i = 15; i > 1; i--) begin
      tick(); expect_out($sformatf("mc15_cnt%0d", i), E_MC);
    end
    tick(); expect_out("mc15_final", E_FIN);
    tick(); clr(); expect_out("mc15_after", E_ZERO);

    // Drain the scoreboard with a bounded wait.
    repeat (4) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
